// File: rtl/half_subtractor.sv
// Registered, lane-parallel 1-bit half subtractor with a result-valid flag
// and a saturating counter of accepted operations that produced any borrow.
module half_subtractor #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [LANES-1:0] diff,
  output logic [LANES-1:0] bor,
  output logic             any_bor,
  output logic [CNT_W-1:0] bor_cnt
);

  logic [LANES-1:0] diff_next;
  logic [LANES-1:0] bor_next;
  logic             any_bor_next;

  logic             out_valid_reg;
  logic [LANES-1:0] diff_reg;
  logic [LANES-1:0] bor_reg;
  logic             any_bor_reg;
  logic [CNT_W-1:0] bor_cnt_reg;
  logic [CNT_W-1:0] bor_cnt_next;
  logic             cnt_sat;

  // Lanes are fully independent: no borrow ripples between them.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign diff_next[gi] = a[gi] ^ b[gi];
      assign bor_next[gi]  = ~a[gi] & b[gi];
    end
  endgenerate

  assign any_bor_next = |bor_next;
  assign cnt_sat      = &bor_cnt_reg;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    bor_cnt_next = bor_cnt_reg;
    if (cnt_clr) begin
      bor_cnt_next = '0;
    end else if (in_valid && any_bor_next && !cnt_sat) begin
      bor_cnt_next = bor_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      diff_reg      <= '0;
      bor_reg       <= '0;
      any_bor_reg   <= 1'b0;
      bor_cnt_reg   <= '0;
    end else begin
      out_valid_reg <= in_valid;
      bor_cnt_reg   <= bor_cnt_next;
      // Results hold across idle cycles; only out_valid drops.
      if (in_valid) begin
        diff_reg    <= diff_next;
        bor_reg     <= bor_next;
        any_bor_reg <= any_bor_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign diff      = diff_reg;
  assign bor       = bor_reg;
  assign any_bor   = any_bor_reg;
  assign bor_cnt   = bor_cnt_reg;

endmodule

// File: tb/tb_half_subtractor.sv
// Directed and randomized checks of half_subtractor: a single-lane instance
// with a wide counter and a four-lane instance with a 2-bit counter.
module tb_half_subtractor;

  logic clk;
  logic rst;

  logic       v1, clr1, a1, b1;
  logic       ov1, d1, br1, ab1;
  logic [15:0] cnt1;

  logic       v4, clr4;
  logic [3:0] a4, b4;
  logic       ov4, ab4;
  logic [3:0] d4, br4;
  logic [1:0] cnt4;

  int tests;
  int fails;

  half_subtractor #(.LANES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cnt_clr(clr1),
    .out_valid(ov1), .diff(d1), .bor(br1), .any_bor(ab1), .bor_cnt(cnt1)
  );

  half_subtractor #(.LANES(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cnt_clr(clr4),
    .out_valid(ov4), .diff(d4), .bor(br4), .any_bor(ab4), .bor_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; clr1 = 0;
    v4 = 0; a4 = '0; b4 = '0; clr4 = 0;
    tick(); tick();
    tests++;
    if ({ov1, d1, br1, ab1, cnt1} !== 20'd0) begin
      fails++;
      $display("FAIL reset_state_dut1: got ov=%b d=%b b=%b any=%b cnt=%0d, expected all 0", ov1, d1, br1, ab1, cnt1);
    end
    tests++;
    if ({ov4, d4, br4, ab4, cnt4} !== 12'd0) begin
      fails++;
      $display("FAIL reset_state_dut4: got ov=%b d=%b b=%b any=%b cnt=%0d, expected all 0", ov4, d4, br4, ab4, cnt4);
    end
    rst = 1'b0;
    // Load non-zero state so the asynchronous reset has something to clear.
    v1 = 1; a1 = 0; b1 = 1;
    v4 = 1; a4 = 4'b0000; b4 = 4'b1111;
    tick();
    tests++;
    if (cnt1 !== 16'd1 || cnt4 !== 2'd1 || d4 !== 4'hf) begin
      fails++;
      $display("FAIL pre_reset_load: got cnt1=%0d cnt4=%0d d4=%b, expected 1 1 1111", cnt1, cnt4, d4);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({ov1, d1, br1, ab1, cnt1} !== 20'd0 || {ov4, d4, br4, ab4, cnt4} !== 12'd0) begin
      fails++;
      $display("FAIL async_reset: got ov1=%b d1=%b b1=%b cnt1=%0d ov4=%b d4=%b b4=%b cnt4=%0d, expected all 0",
               ov1, d1, br1, cnt1, ov4, d4, br4, cnt4);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (cnt1 !== 16'd0 || cnt4 !== 2'd0 || ov1 !== 1'b0 || ov4 !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold_%0d: got cnt1=%0d cnt4=%0d ov1=%b ov4=%b, expected 0 0 0 0", i, cnt1, cnt4, ov1, ov4);
      end
    end
    rst = 1'b0;
    v1 = 0; v4 = 0;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_db [4];
    logic [1:0] ab;
    exp_db[0] = 2'b00; exp_db[1] = 2'b11; exp_db[2] = 2'b10; exp_db[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      v1 = 1; a1 = ab[1]; b1 = ab[0];
      tick();
      tests++;
      if ({d1, br1} !== exp_db[i] || ov1 !== 1'b1 || ab1 !== exp_db[i][0]) begin
        fails++;
        $display("FAIL truth_ab%0d: got diff=%b bor=%b ov=%b any=%b, expected diff=%b bor=%b ov=1 any=%b",
                 i, d1, br1, ov1, ab1, exp_db[i][1], exp_db[i][0], exp_db[i][0]);
      end
    end
    v1 = 0;
    tick();
    tests++;
    if (cnt1 !== 16'd1) begin
      fails++;
      $display("FAIL truth_cnt: got bor_cnt=%0d, expected 1", cnt1);
    end
  endtask

  task automatic test_multi_lane();
    v4 = 1; a4 = 4'b1010; b4 = 4'b0110;
    tick();
    tests++;
    if (d4 !== 4'b1100 || br4 !== 4'b0100 || ab4 !== 1'b1 || ov4 !== 1'b1 || cnt4 !== 2'd1) begin
      fails++;
      $display("FAIL lanes_1010_0110: got diff=%b bor=%b any=%b ov=%b cnt=%0d, expected 1100 0100 1 1 1",
               d4, br4, ab4, ov4, cnt4);
    end
    a4 = 4'b1111; b4 = 4'b0000;
    tick();
    tests++;
    if (d4 !== 4'b1111 || br4 !== 4'b0000 || ab4 !== 1'b0 || ov4 !== 1'b1 || cnt4 !== 2'd1) begin
      fails++;
      $display("FAIL lanes_1111_0000: got diff=%b bor=%b any=%b ov=%b cnt=%0d, expected 1111 0000 0 1 1",
               d4, br4, ab4, ov4, cnt4);
    end
  endtask

  task automatic test_valid_gating();
    v4 = 1; a4 = 4'b0000; b4 = 4'b0101;
    tick();
    tests++;
    if (d4 !== 4'b0101 || br4 !== 4'b0101 || ab4 !== 1'b1 || cnt4 !== 2'd2) begin
      fails++;
      $display("FAIL gating_load: got diff=%b bor=%b any=%b cnt=%0d, expected 0101 0101 1 2", d4, br4, ab4, cnt4);
    end
    v4 = 0; a4 = 4'b0000; b4 = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (ov4 !== 1'b0 || d4 !== 4'b0101 || br4 !== 4'b0101 || ab4 !== 1'b1 || cnt4 !== 2'd2) begin
        fails++;
        $display("FAIL gating_idle_%0d: got ov=%b diff=%b bor=%b any=%b cnt=%0d, expected 0 0101 0101 1 2",
                 i, ov4, d4, br4, ab4, cnt4);
      end
      a4 = 4'b0011; b4 = 4'b1100;
    end
  endtask

  task automatic test_counter_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    clr4 = 1; v4 = 0;
    tick();
    clr4 = 0;
    tests++;
    if (cnt4 !== 2'd0) begin
      fails++;
      $display("FAIL cnt_clear_idle: got bor_cnt=%0d, expected 0", cnt4);
    end
    for (int i = 0; i < 5; i++) begin
      v4 = 1; a4 = 4'b0000; b4 = 4'b0001;
      tick();
      tests++;
      if (cnt4 !== exp_cnt[i]) begin
        fails++;
        $display("FAIL cnt_sat_%0d: got bor_cnt=%0d, expected %0d", i, cnt4, exp_cnt[i]);
      end
    end
    clr4 = 1; v4 = 1; a4 = 4'b0000; b4 = 4'b1000;
    tick();
    clr4 = 0; v4 = 0;
    tests++;
    if (cnt4 !== 2'd0 || d4 !== 4'b1000 || br4 !== 4'b1000 || ov4 !== 1'b1) begin
      fails++;
      $display("FAIL cnt_clr_wins: got cnt=%0d diff=%b bor=%b ov=%b, expected 0 1000 1000 1", cnt4, d4, br4, ov4);
    end
  endtask

  task automatic test_random();
    logic        m_ov1, m_d1, m_b1, m_any1;
    logic [15:0] m_cnt1;
    logic        m_ov4, m_any4;
    logic [3:0]  m_d4, m_b4;
    logic [1:0]  m_cnt4;
    logic [3:0]  bw4;
    logic        bw1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ov1 = 0; m_d1 = 0; m_b1 = 0; m_any1 = 0; m_cnt1 = 0;
    m_ov4 = 0; m_d4 = 0; m_b4 = 0; m_any4 = 0; m_cnt4 = 0;
    for (int i = 0; i < 1000; i++) begin
      v1 = 1'($urandom_range(0, 1)); a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
      clr1 = ($urandom_range(0, 63) == 0);
      v4 = 1'($urandom_range(0, 1)); a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
      clr4 = ($urandom_range(0, 15) == 0);
      bw1 = ~a1 & b1;
      bw4 = ~a4 & b4;
      m_ov1 = v1;
      if (v1) begin m_d1 = a1 ^ b1; m_b1 = bw1; m_any1 = bw1; end
      if (clr1) m_cnt1 = 0;
      else if (v1 && bw1 && m_cnt1 != 16'hffff) m_cnt1 = m_cnt1 + 16'd1;
      m_ov4 = v4;
      if (v4) begin m_d4 = a4 ^ b4; m_b4 = bw4; m_any4 = (bw4 != 4'd0); end
      if (clr4) m_cnt4 = 0;
      else if (v4 && bw4 != 4'd0 && m_cnt4 != 2'd3) m_cnt4 = m_cnt4 + 2'd1;
      tick();
      tests++;
      if ({ov1, d1, br1, ab1, cnt1} !== {m_ov1, m_d1, m_b1, m_any1, m_cnt1}) begin
        fails++;
        $display("FAIL random1_%0d: got ov=%b d=%b b=%b any=%b cnt=%0d, expected ov=%b d=%b b=%b any=%b cnt=%0d",
                 i, ov1, d1, br1, ab1, cnt1, m_ov1, m_d1, m_b1, m_any1, m_cnt1);
      end
      tests++;
      if ({ov4, d4, br4, ab4, cnt4} !== {m_ov4, m_d4, m_b4, m_any4, m_cnt4}) begin
        fails++;
        $display("FAIL random4_%0d: got ov=%b d=%b b=%b any=%b cnt=%0d, expected ov=%b d=%b b=%b any=%b cnt=%0d",
                 i, ov4, d4, br4, ab4, cnt4, m_ov4, m_d4, m_b4, m_any4, m_cnt4);
      end
    end
    v1 = 0; v4 = 0; clr1 = 0; clr4 = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_truth_table();
    test_multi_lane();
    test_valid_gating();
    test_counter_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
